// File: rtl/imm_extend_stage.sv
// imm_extend_stage: registered immediate extender for the ID stage.
// Extends an IN_W-bit immediate to OUT_W bits (sign / zero / upper / branch)
// and holds results in a 2-entry skid buffer ahead of the ID/EX register.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high on that side. valid never waits for ready. in_ready_o depends only on
// registered occupancy and rst_i, never on out_ready_i.
//
// Optional feature: define IMM_EXT_CNT_EN to add xfer_cnt_o, a free-running
// count of accepted pushes (wraps modulo 2^CNT_W, cleared only by reset).
module imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IN_W-1:0]  data_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [OUT_W-1:0] data_o,
    output logic [1:0]       mode_o
`ifdef IMM_EXT_CNT_EN
    ,
    output logic [CNT_W-1:0] xfer_cnt_o
`endif
);

    localparam int EXT_W = OUT_W - IN_W;

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    // The branch mode shifts the sign-extended value left by two, so at least
    // two extension bits are needed for the shift to stay meaningful.
    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("imm_extend_stage: OUT_W must be at least IN_W+2");
        end
    endgenerate

    // Buffer storage: head is what the consumer sees, tail is the skid slot.
    logic [OUT_W-1:0] head_data_q, head_data_d;
    logic [1:0]       head_mode_q, head_mode_d;
    logic [OUT_W-1:0] tail_data_q, tail_data_d;
    logic [1:0]       tail_mode_q, tail_mode_d;
    logic [1:0]       count_q, count_d;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;

    assign in_ready_o  = rst_i & (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign data_o      = head_data_q;
    assign mode_o      = head_mode_q;

    assign push = in_valid_i & in_ready_o;
    assign pop  = out_valid_o & out_ready_i;

    // Extend the incoming immediate according to its mode before it is stored.
    always_comb begin
        sext     = {{EXT_W{data_i[IN_W-1]}}, data_i};
        ext_data = sext;
        case (mode_i)
            MODE_SIGN:   ext_data = sext;
            MODE_ZERO:   ext_data = {{EXT_W{1'b0}}, data_i};
            MODE_UPPER:  ext_data = {data_i, {EXT_W{1'b0}}};
            MODE_BRANCH: ext_data = {sext[OUT_W-3:0], 2'b00};
            default:     ext_data = sext;
        endcase
    end

    // Buffer next state: flush empties, push/pop move entries between slots.
    always_comb begin
        head_data_d = head_data_q;
        head_mode_d = head_mode_q;
        tail_data_d = tail_data_q;
        tail_mode_d = tail_mode_q;
        count_d     = count_q;

        if (flush_i) begin
            // Entry contents are left in place; only occupancy is discarded.
            count_d = 2'd0;
        end else if (push && pop) begin
            // Push is only possible below full, so occupancy is 1 here: the
            // departing head is replaced directly by the new entry.
            head_data_d = ext_data;
            head_mode_d = mode_i;
        end else if (push) begin
            if (count_q == 2'd0) begin
                head_data_d = ext_data;
                head_mode_d = mode_i;
            end else begin
                tail_data_d = ext_data;
                tail_mode_d = mode_i;
            end
            count_d = count_q + 2'd1;
        end else if (pop) begin
            head_data_d = tail_data_q;
            head_mode_d = tail_mode_q;
            count_d     = count_q - 2'd1;
        end
    end

    // Buffer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            head_data_q <= '0;
            head_mode_q <= 2'b00;
            tail_data_q <= '0;
            tail_mode_q <= 2'b00;
            count_q     <= 2'd0;
        end else begin
            head_data_q <= head_data_d;
            head_mode_q <= head_mode_d;
            tail_data_q <= tail_data_d;
            tail_mode_q <= tail_mode_d;
            count_q     <= count_d;
        end
    end

`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

    // Count only pushes that actually land; a flush discards the input word.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (push && !flush_i) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // Transfer counter register, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            xfer_cnt_q <= '0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage (IN_W=16, OUT_W=32).
// Inputs change 1 time unit after each rising edge; outputs are checked there.
module tb_imm_extend_stage;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  data_in;
    logic [1:0]       mode_in;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] data_out;
    logic [1:0]       mode_out;
`ifdef IMM_EXT_CNT_EN
    logic [CNT_W-1:0] xfer_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [OUT_W-1:0] exp_q[$];

    imm_extend_stage #(
        .IN_W (IN_W),
        .OUT_W(OUT_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .data_i     (data_in),
        .mode_i     (mode_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .data_o     (data_out),
        .mode_o     (mode_out)
`ifdef IMM_EXT_CNT_EN
        ,
        .xfer_cnt_o (xfer_cnt)
`endif
    );

    // Clock and cycle helpers
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_in(input logic v, input logic [IN_W-1:0] d, input logic [1:0] m);
        in_valid = v;
        data_in  = d;
        mode_in  = m;
    endtask

    // Scoreboard: if the visible head will be taken this edge, compare it.
    task automatic sb_pop_check(input string tag);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check({tag, "_unexpected"}, 32'd1, 32'd0);
            end else begin
                check(tag, data_out, exp_q.pop_front());
            end
        end
    endtask

    // Mode vectors: raw immediate, mode, expected extended value
    logic [15:0] vec_d[4] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF};
    logic [1:0]  vec_m[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] vec_e[4] = '{32'hFFFF8000, 32'h00008000, 32'h12340000, 32'hFFFFFFFC};

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive_in(1'b0, '0, 2'b00);

        // Reset state
        step();
        step();
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", data_out, 32'd0);
        check("rst_mode", {30'd0, mode_out}, 32'd0);
`ifdef IMM_EXT_CNT_EN
        check("rst_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Each mode, consumer always ready: result one cycle after push
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_in(1'b1, vec_d[i], vec_m[i]);
            step();
            check($sformatf("mode%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("mode%0d_data", i), data_out, vec_e[i]);
            check($sformatf("mode%0d_tag", i), {30'd0, mode_out}, {30'd0, vec_m[i]});
        end
        drive_in(1'b0, '0, 2'b00);
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Empty buffer ignores out_ready
        step();
        check("empty_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: fill with A, B; C is held off
        out_ready = 1'b0;
        drive_in(1'b1, 16'h0011, 2'b01);
        exp_q.push_back(32'h00000011);
        step();
        drive_in(1'b1, 16'hFF00, 2'b00);
        exp_q.push_back(32'hFFFFFF00);
        step();
        check("full_in_ready", {31'd0, in_ready}, 32'd0);
        drive_in(1'b1, 16'h0033, 2'b10);
        step();
        check("held_in_ready", {31'd0, in_ready}, 32'd0);
        check("held_head", data_out, 32'h00000011);

        // Full with simultaneous pop: no push this edge, C lands next edge
        out_ready = 1'b1;
        sb_pop_check("order_a");
        step();
        check("after_full_pop_ready", {31'd0, in_ready}, 32'd1);
        exp_q.push_back(32'h00330000);
        sb_pop_check("order_b");
        step();
        sb_pop_check("order_c");
        drive_in(1'b0, '0, 2'b00);
        step();
        check("order_drained", {31'd0, out_valid}, 32'd0);
        check("order_sb_empty", exp_q.size(), 32'd0);

        // Flush while full with a word offered
        out_ready = 1'b0;
        drive_in(1'b1, 16'h0005, 2'b01);
        step();
        drive_in(1'b1, 16'h0006, 2'b01);
        step();
        flush = 1'b1;
        drive_in(1'b1, 16'h0001, 2'b01);
        #1;
        check("flush_ready_unaffected", {31'd0, in_ready}, 32'd0);
        step();
        flush = 1'b0;
        drive_in(1'b0, '0, 2'b00);
        check("flush_full_valid", {31'd0, out_valid}, 32'd0);
        check("flush_full_ready", {31'd0, in_ready}, 32'd1);

        // Flush with one entry and an accepted push: the new word is lost too
        drive_in(1'b1, 16'h0007, 2'b01);
        step();
        flush = 1'b1;
        out_ready = 1'b1;
        drive_in(1'b1, 16'h0001, 2'b01);
        step();
        flush = 1'b0;
        drive_in(1'b0, '0, 2'b00);
        check("flush_one_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("flush_word_lost", {31'd0, out_valid}, 32'd0);

        // Reset in mid-operation with one entry buffered
        out_ready = 1'b0;
        drive_in(1'b1, 16'h7FFF, 2'b11);
        step();
        drive_in(1'b0, '0, 2'b00);
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_data", data_out, 32'h0001FFFC);
        check("pre_rst_mode", {30'd0, mode_out}, 32'd3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_data", data_out, 32'd0);
        check("mid_rst_mode", {30'd0, mode_out}, 32'd0);
`ifdef IMM_EXT_CNT_EN
        check("mid_rst_cnt", {28'd0, xfer_cnt}, 32'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        check("after_rst_valid", {31'd0, out_valid}, 32'd0);

`ifdef IMM_EXT_CNT_EN
        // Counter wrap: 17 pushes into a 4-bit counter leave it at 1
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive_in(1'b1, 16'(i), 2'b01);
            step();
        end
        drive_in(1'b0, '0, 2'b00);
        check("cnt_wrap", {28'd0, xfer_cnt}, 32'd1);
`endif

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
